// File: rtl/pcie_phy_pkg.sv
// Shared link-layer constants and state encoding for the PCIe-style PHY blocks.
package pcie_phy_pkg;

    localparam logic [7:0] COM_SYMBOL            = 8'hBC;
    localparam int         COM_TO_ACTIVE_DEFAULT = 4;

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        SYNC   = 2'd1,
        ACTIVE = 2'd2
    } align_state_t;

endpackage

// File: rtl/serial_paralelo.sv
// Receive deserializer: finds byte alignment on the COM symbol, then rebuilds
// MSB-first bytes, flagging data bytes valid and COM idle fill invalid.
module serial_paralelo
    import pcie_phy_pkg::*;
#(
    parameter logic [7:0] COM           = COM_SYMBOL,
    parameter int         COM_TO_ACTIVE = COM_TO_ACTIVE_DEFAULT
) (
    input  logic       clk32_f,
    input  logic       reset,
    input  logic       data_in,
    output logic [7:0] data_out,
    output logic       valid_out,
    output logic       active
);

    localparam int BC_W = $clog2(COM_TO_ACTIVE + 1);

    align_state_t      state;
    logic [7:0]        sr;
    logic [2:0]        bit_cnt;
    logic [BC_W-1:0]   bc_cnt;
    logic [7:0]        w;
    logic [BC_W-1:0]   bc_next;
    logic              is_com;
    logic              boundary;

    // Window of the 8 most recent bits including the one being sampled now.
    assign w        = {sr[6:0], data_in};
    assign is_com   = (w == COM);
    assign boundary = (bit_cnt == 3'd7);
    assign bc_next  = bc_cnt + BC_W'(1);

    always_ff @(posedge clk32_f) begin
        if (reset) begin
            state     <= HUNT;
            sr        <= 8'h00;
            bit_cnt   <= 3'd0;
            bc_cnt    <= '0;
            data_out  <= 8'h00;
            valid_out <= 1'b0;
            active    <= 1'b0;
        end else begin
            sr <= w;
            case (state)
                HUNT: begin
                    if (is_com) begin
                        // This COM fixes the boundary; the next sample is bit 0.
                        bit_cnt <= 3'd0;
                        if (COM_TO_ACTIVE <= 1) begin
                            state  <= ACTIVE;
                            active <= 1'b1;
                            bc_cnt <= BC_W'(COM_TO_ACTIVE);
                        end else begin
                            state  <= SYNC;
                            bc_cnt <= BC_W'(1);
                        end
                    end
                end

                SYNC: begin
                    bit_cnt <= bit_cnt + 3'd1;
                    if (boundary) begin
                        if (is_com) begin
                            if (bc_cnt != BC_W'(COM_TO_ACTIVE)) begin
                                bc_cnt <= bc_next;
                            end
                            if (bc_next == BC_W'(COM_TO_ACTIVE)) begin
                                state  <= ACTIVE;
                                active <= 1'b1;
                            end
                        end else begin
                            state   <= HUNT;
                            bc_cnt  <= '0;
                            bit_cnt <= 3'd0;
                        end
                    end
                end

                ACTIVE: begin
                    bit_cnt <= bit_cnt + 3'd1;
                    // No loss-of-lock detection: only reset leaves ACTIVE.
                    if (boundary) begin
                        data_out  <= w;
                        valid_out <= !is_com;
                    end
                end

                default: begin
                    state   <= HUNT;
                    bc_cnt  <= '0;
                    bit_cnt <= 3'd0;
                    active  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_paralelo.sv
// Directed self-checking bench for serial_paralelo: alignment, data recovery,
// fallback to HUNT, mid-byte reset and an interleaved data/idle byte stream.
module tb_serial_paralelo;

    logic       clk32_f = 1'b0;
    logic       reset   = 1'b1;
    logic       data_in = 1'b0;
    logic [7:0] data_out;
    logic       valid_out;
    logic       active;

    int n_checks = 0;
    int n_pass   = 0;

    logic [7:0] exp_data  = 8'h00;
    logic       exp_valid = 1'b0;
    logic       cur_act   = 1'b0;
    logic [7:0] rx_q[$];
    logic [7:0] exp_q[$];

    serial_paralelo dut (
        .clk32_f   (clk32_f),
        .reset     (reset),
        .data_in   (data_in),
        .data_out  (data_out),
        .valid_out (valid_out),
        .active    (active)
    );

    always #5 clk32_f = ~clk32_f;

    task automatic check(input string tag, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            $display("FAIL %s: got %h, expected %h (t=%0t)", tag, act, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    task automatic check_outputs(input string tag);
        check({tag, ".data"},   data_out,        exp_data);
        check({tag, ".valid"},  {7'd0, valid_out}, {7'd0, exp_valid});
        check({tag, ".active"}, {7'd0, active},    {7'd0, cur_act});
    endtask

    // Drive one bit; outputs are sampled 1 time unit after the active edge.
    task automatic send_bit(input logic b);
        data_in = b;
        @(posedge clk32_f);
        #1;
    endtask

    task automatic do_reset();
        reset   = 1'b1;
        data_in = 1'b0;
        @(posedge clk32_f);
        #1;
        reset     = 1'b0;
        exp_data  = 8'h00;
        exp_valid = 1'b0;
        cur_act   = 1'b0;
        check_outputs("reset");
    endtask

    // upd: this byte's boundary falls in ACTIVE and updates the outputs.
    // act_after: expected active right after the byte's last bit is sampled.
    task automatic send_byte(input logic [7:0] b, input logic upd, input logic act_after,
                             input string tag);
        for (int i = 7; i >= 0; i--) begin
            send_bit(b[i]);
            if (i == 0) begin
                if (upd) begin
                    exp_data  = b;
                    exp_valid = (b != 8'hBC);
                    if (valid_out) rx_q.push_back(data_out);
                end
                cur_act = act_after;
            end
            check_outputs(tag);
        end
    endtask

    initial begin
        logic [7:0] a5;
        a5 = 8'hA5;

        // Reset and idle zeros: nothing aligns.
        do_reset();
        for (int i = 0; i < 16; i++) begin
            send_bit(1'b0);
            check_outputs("idle_zero");
        end

        // Random misalignment, then 4 COMs: active rises at the last bit of the 4th.
        for (int i = 0; i < 3; i++) send_bit(1'($urandom_range(0, 1)));
        send_byte(8'hBC, 1'b0, 1'b0, "com1");
        send_byte(8'hBC, 1'b0, 1'b0, "com2");
        send_byte(8'hBC, 1'b0, 1'b0, "com3");
        send_byte(8'hBC, 1'b0, 1'b1, "com4");

        // Data recovery: BC, 5A, FF, BC with valid 0,1,1,0.
        send_byte(8'hBC, 1'b1, 1'b1, "act_bc0");
        send_byte(8'h5A, 1'b1, 1'b1, "act_5a");
        send_byte(8'hFF, 1'b1, 1'b1, "act_ff");
        send_byte(8'hBC, 1'b1, 1'b1, "act_bc1");

        // From reset: BC, BC, 0x12 drops back to HUNT; then a fresh 4-COM run aligns.
        do_reset();
        send_byte(8'hBC, 1'b0, 1'b0, "fb_com1");
        send_byte(8'hBC, 1'b0, 1'b0, "fb_com2");
        send_byte(8'h12, 1'b0, 1'b0, "fb_12");
        send_byte(8'hBC, 1'b0, 1'b0, "re_com1");
        send_byte(8'hBC, 1'b0, 1'b0, "re_com2");
        send_byte(8'hBC, 1'b0, 1'b0, "re_com3");
        send_byte(8'hBC, 1'b0, 1'b1, "re_com4");
        send_byte(8'h5A, 1'b1, 1'b1, "re_5a");

        // Reset mid-byte in ACTIVE clears everything; realign with 4 fresh COMs.
        send_bit(a5[7]);
        send_bit(a5[6]);
        send_bit(a5[5]);
        do_reset();
        send_byte(8'hBC, 1'b0, 1'b0, "rs_com1");
        send_byte(8'hBC, 1'b0, 1'b0, "rs_com2");
        send_byte(8'hBC, 1'b0, 1'b0, "rs_com3");
        send_byte(8'hBC, 1'b0, 1'b1, "rs_com4");

        // Serializer-style stream: data 0x01..0x08 with COM idle fill in between.
        rx_q.delete();
        for (int k = 1; k <= 8; k++) begin
            if (k % 2 == 1) send_byte(8'hBC, 1'b1, 1'b1, "lb_idle");
            exp_q.push_back(8'(k));
            send_byte(8'(k), 1'b1, 1'b1, "lb_data");
        end
        send_byte(8'hBC, 1'b1, 1'b1, "lb_tail");

        check("lb_count", 8'(rx_q.size()), 8'd8);
        for (int k = 0; k < 8; k++) begin
            if (k < rx_q.size()) check("lb_byte", rx_q[k], exp_q[k]);
            else                 check("lb_byte", 8'hXX, exp_q[k]);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
